// File: rtl/load_store_sequencer_if.sv
// Request handshake and memory/datapath control bundle for the load/store sequencer.
// The master side is the control FSM plus memory; the slave side is the sequencer.
interface load_store_sequencer_if;
  logic        start;
  logic        op_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [1:0]  ls_control;
  logic        mdr_load;
  logic        reg_write;
  logic        busy;
  logic        done;

  modport master (
    output start, op_store, size, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, ls_control, mdr_load, reg_write, busy, done
  );

  modport slave (
    input  start, op_store, size, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, ls_control, mdr_load, reg_write, busy, done
  );
endinterface

// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer: loads go through the MDR, sub-word stores are
// done as read-modify-write on the 32-bit memory port.
module load_store_sequencer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  load_store_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    LATCH,
    WB,
    MERGE,
    WR
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic        op_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merge_q;
  logic [3:0]  lat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture, read-latency countdown and the read-modify-write merge register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      merge_q <= 32'h0;
      lat_cnt <= 4'h0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q   <= bus.op_store;
        size_q <= bus.size;
        addr_q <= bus.addr;
        data_q <= bus.store_data;
      end
      if (state != RD_WAIT && state_next == RD_WAIT) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == RD_WAIT && lat_cnt != 4'h0) begin
        lat_cnt <= lat_cnt - 4'h1;
      end
      if (state == MERGE) begin
        merge_q <= size_q[1] ? {bus.mem_rdata[31:8],  data_q[7:0]}
                             : {bus.mem_rdata[31:16], data_q[15:0]};
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.op_store && bus.size == 2'b00) ? WR : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 4'h0) begin
          state_next = op_q ? MERGE : LATCH;
        end
      end
      LATCH:   state_next = WB;
      WB:      state_next = IDLE;
      MERGE:   state_next = WR;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore decodes of the state and captured request.
  always_comb begin
    bus.busy       = (state != IDLE);
    bus.done       = (state == WB) || (state == WR);
    bus.mem_wr     = (state == WR);
    bus.mdr_load   = (state == LATCH);
    bus.reg_write  = (state == WB);
    bus.mem_addr   = (state != IDLE) ? addr_q : 32'h0;
    bus.ls_control = (state != IDLE) ? size_q : 2'b00;
    bus.mem_wdata  = 32'h0;
    if (state == WR) begin
      bus.mem_wdata = (size_q == 2'b00) ? data_q : merge_q;
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: two instances (latency 1 and 4) driven with the same
// requests and checked cycle by cycle against a timeline model of each operation.
module tb_load_store_sequencer;

  typedef struct {
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] word;
  } reqT;

  typedef struct {
    reqT         r;
    bit          noise;
    int          done1;
    int          done4;
    logic [31:0] expVal;
  } vecT;

  typedef struct {
    logic        busy;
    logic        done;
    logic        memWr;
    logic        mdrLoad;
    logic        regWrite;
    logic [1:0]  lsControl;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
  } obsT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  int          obsDone [2];
  logic [31:0] obsWr   [2];
  logic [31:0] obsMdr  [2];

  load_store_sequencer_if ifA ();
  load_store_sequencer_if ifB ();

  load_store_sequencer #(.MEM_LATENCY(1)) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA.slave));
  load_store_sequencer #(.MEM_LATENCY(4)) dutB (.clk(clk), .reset_n(reset_n), .bus(ifB.slave));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int w);
    return (w == 0) ? 1 : 4;
  endfunction

  function automatic int doneCycle(input reqT r, input int lat);
    return (r.op && r.size == 2'b00) ? 1 : lat + 2;
  endfunction

  function automatic logic [31:0] storeImage(input reqT r);
    if (r.size == 2'b00)  return r.sd;
    else if (r.size[1])   return {r.word[31:8], r.sd[7:0]};
    else                  return {r.word[31:16], r.sd[15:0]};
  endfunction

  function automatic logic [31:0] muxOut(input logic [31:0] mdr, input logic [1:0] size);
    if (size[1])       return {24'h0, mdr[7:0]};
    else if (size[0])  return {16'h0, mdr[15:0]};
    else               return mdr;
  endfunction

  function automatic obsT sampleBus(input int w);
    obsT o;
    if (w == 0) begin
      o.busy = ifA.busy; o.done = ifA.done; o.memWr = ifA.mem_wr; o.mdrLoad = ifA.mdr_load;
      o.regWrite = ifA.reg_write; o.lsControl = ifA.ls_control;
      o.memAddr = ifA.mem_addr; o.memWdata = ifA.mem_wdata;
    end else begin
      o.busy = ifB.busy; o.done = ifB.done; o.memWr = ifB.mem_wr; o.mdrLoad = ifB.mdr_load;
      o.regWrite = ifB.reg_write; o.lsControl = ifB.ls_control;
      o.memAddr = ifB.mem_addr; o.memWdata = ifB.mem_wdata;
    end
    return o;
  endfunction

  task automatic applyStimulus(input int w, input logic st, input reqT r);
    if (w == 0) begin
      ifA.start = st; ifA.op_store = r.op; ifA.size = r.size; ifA.addr = r.addr; ifA.store_data = r.sd;
    end else begin
      ifB.start = st; ifB.op_store = r.op; ifB.size = r.size; ifB.addr = r.addr; ifB.store_data = r.sd;
    end
  endtask

  task automatic setRdata(input int w, input logic [31:0] v);
    if (w == 0) ifA.mem_rdata = v;
    else        ifB.mem_rdata = v;
  endtask

  task automatic cmp(input string name, input int w, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s dut=%0d got=%h want=%h", name, w, got, want);
    end
  endtask

  // Expected outputs in cycle k after the capture edge, from the operation's timeline.
  task automatic checkOutput(input int w, input int k, input reqT r, input obsT o);
    int  lat;
    int  d;
    bit  inBusy;
    bit  fin;
    lat    = latOf(w);
    d      = doneCycle(r, lat);
    inBusy = (k >= 1) && (k <= d);
    fin    = (k == d);
    cmp($sformatf("busy@%0d", k),      w, 32'(o.busy),      32'(inBusy));
    cmp($sformatf("done@%0d", k),      w, 32'(o.done),      32'(fin));
    cmp($sformatf("mem_wr@%0d", k),    w, 32'(o.memWr),     32'(r.op && fin));
    cmp($sformatf("mdr_load@%0d", k),  w, 32'(o.mdrLoad),   32'(!r.op && k == lat + 1));
    cmp($sformatf("reg_write@%0d", k), w, 32'(o.regWrite),  32'(!r.op && fin));
    cmp($sformatf("ls_control@%0d", k),w, 32'(o.lsControl), inBusy ? 32'(r.size) : 32'h0);
    cmp($sformatf("mem_addr@%0d", k),  w, o.memAddr,        inBusy ? r.addr : 32'h0);
    cmp($sformatf("mem_wdata@%0d", k), w, o.memWdata,       (r.op && fin) ? storeImage(r) : 32'h0);
  endtask

  task automatic checkZero(input string tag);
    obsT o;
    for (int w = 0; w < 2; w++) begin
      o = sampleBus(w);
      cmp({tag, "_busy"},  w, 32'(o.busy), 32'h0);
      cmp({tag, "_done"},  w, 32'(o.done), 32'h0);
      cmp({tag, "_wr"},    w, 32'(o.memWr), 32'h0);
      cmp({tag, "_mdr"},   w, 32'(o.mdrLoad), 32'h0);
      cmp({tag, "_rw"},    w, 32'(o.regWrite), 32'h0);
      cmp({tag, "_lsc"},   w, 32'(o.lsControl), 32'h0);
      cmp({tag, "_addr"},  w, o.memAddr, 32'h0);
      cmp({tag, "_wdata"}, w, o.memWdata, 32'h0);
    end
  endtask

  function automatic reqT randReq();
    reqT r;
    r.op   = 1'($urandom_range(0, 1));
    r.size = 2'($urandom_range(0, 3));
    r.addr = $urandom;
    r.sd   = $urandom;
    r.word = $urandom;
    return r;
  endfunction

  // One request on both instances; memory returns junk until the read latency has elapsed.
  task automatic runTxn(input reqT r, input bit noise);
    obsT         o;
    logic [31:0] rd;
    int          lat;
    int          d;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      applyStimulus(w, 1'b1, r);
      setRdata(w, 32'hBAD0_0000);
      obsDone[w] = 0;
      obsWr[w]   = 32'h0;
      obsMdr[w]  = 32'h0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        lat = latOf(w);
        d   = doneCycle(r, lat);
        o   = sampleBus(w);
        checkOutput(w, k, r, o);
        if (o.done)  obsDone[w] = k;
        if (o.memWr) obsWr[w] = o.memWdata;
        rd = (k >= lat + 1) ? r.word : (32'hBAD0_0000 | 32'(k));
        setRdata(w, rd);
        if (o.mdrLoad) obsMdr[w] = rd;
        if (noise && k <= d)
          applyStimulus(w, (k == d) ? 1'b1 : 1'($urandom_range(0, 1)), randReq());
        else
          applyStimulus(w, 1'b0, r);
      end
    end
  endtask

  vecT vecs [7];
  reqT rq;

  initial begin
    vecs[0] = '{'{1'b0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF}, 1'b0, 3, 6, 32'hDEADBEEF};
    vecs[1] = '{'{1'b0, 2'b11, 32'h21, 32'h0,        32'h12345678}, 1'b0, 3, 6, 32'h00000078};
    vecs[2] = '{'{1'b1, 2'b01, 32'h40, 32'hAAAABBBB, 32'h11223344}, 1'b0, 3, 6, 32'h1122BBBB};
    vecs[3] = '{'{1'b1, 2'b10, 32'h40, 32'hAAAABBBB, 32'h11223344}, 1'b0, 3, 6, 32'h112233BB};
    vecs[4] = '{'{1'b1, 2'b00, 32'h80, 32'hCAFEF00D, 32'h0},        1'b0, 1, 1, 32'hCAFEF00D};
    vecs[5] = '{'{1'b0, 2'b01, 32'h44, 32'h0,        32'h89ABCDEF}, 1'b1, 3, 6, 32'h0000CDEF};
    vecs[6] = '{'{1'b1, 2'b11, 32'h43, 32'h0000005A, 32'hFFFFFFFF}, 1'b1, 3, 6, 32'hFFFFFF5A};

    rq = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0};
    for (int w = 0; w < 2; w++) begin
      applyStimulus(w, 1'b0, rq);
      setRdata(w, 32'h0);
    end
    #1;
    checkZero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkZero("idle");

    for (int i = 0; i < 7; i++) begin
      runTxn(vecs[i].r, vecs[i].noise);
      cmp($sformatf("vec%0d_done", i), 0, 32'(obsDone[0]), 32'(vecs[i].done1));
      cmp($sformatf("vec%0d_done", i), 1, 32'(obsDone[1]), 32'(vecs[i].done4));
      for (int w = 0; w < 2; w++) begin
        if (vecs[i].r.op)
          cmp($sformatf("vec%0d_wdata", i), w, obsWr[w], vecs[i].expVal);
        else
          cmp($sformatf("vec%0d_load", i), w, muxOut(obsMdr[w], vecs[i].r.size), vecs[i].expVal);
      end
    end

    // Reset during the read phase of a halfword store must abandon it without a write.
    rq = vecs[2].r;
    @(negedge clk);
    for (int w = 0; w < 2; w++) applyStimulus(w, 1'b1, rq);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      applyStimulus(w, 1'b0, rq);
      setRdata(w, 32'h11223344);
      cmp("pre_rst_busy", w, 32'(sampleBus(w).busy), 32'h1);
    end
    reset_n = 1'b0;
    #1;
    checkZero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkZero("inrst");
    end
    reset_n = 1'b1;
    runTxn(rq, 1'b0);
    cmp("post_rst_done", 0, 32'(obsDone[0]), 32'd3);
    cmp("post_rst_done", 1, 32'(obsDone[1]), 32'd6);
    cmp("post_rst_wdata", 0, obsWr[0], 32'h1122BBBB);
    cmp("post_rst_wdata", 1, obsWr[1], 32'h1122BBBB);

    for (int i = 0; i < 40; i++) begin
      rq = randReq();
      runTxn(rq, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
